// File: rtl/pid_pkg.sv
// Shared PID arithmetic constants, FSM state type and saturating clamps
// used by the P, I and D contribution paths.
package pid_pkg;

    localparam int W     = 6;              // data width of e, K_i, i_contrib
    localparam int ACC_W = 10;             // signed accumulator width
    localparam int FRAC  = 4;              // product right shift before output clamp
    localparam int P_W   = ACC_W + W;      // full product width, no overflow possible
    localparam int SH_W  = P_W - FRAC;     // width of the shifted product
    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        OUT
    } state_e;

    // Clamp an ACC_W+1 bit sum into ACC_W bits: overflow shows as the two top bits differing.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] x);
        logic signed [ACC_W-1:0] res;
        if (x[ACC_W] != x[ACC_W-1]) begin
            res = x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            res = x[ACC_W-1:0];
        end
        return res;
    endfunction

    // Clamp the shifted product into W bits; it fits only if all bits above W-2 agree.
    function automatic logic signed [W-1:0] sat_out(input logic signed [SH_W-1:0] x);
        logic [SH_W-W:0]     hi;
        logic signed [W-1:0] res;
        hi = x[SH_W-1:W-1];
        if (hi == '0 || hi == '1) begin
            res = x[W-1:0];
        end else begin
            res = x[SH_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_shift_add_mul.sv
// Sequential shift-add multiplier: signed ACC_W multiplicand times unsigned
// W-bit multiplier, one multiplier bit per clock, W clocks after start.
module seq_shift_add_mul
    import pid_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic signed [ACC_W-1:0] mcand_i,
    input  logic        [W-1:0]     mplier_i,
    output logic signed [P_W-1:0]   product_o,
    output logic                    done_o
);

    logic                    running_q, running_d;
    logic        [CNT_W-1:0] cnt_q,     cnt_d;
    logic signed [ACC_W-1:0] mcand_q,   mcand_d;
    logic        [W-1:0]     mplier_q,  mplier_d;
    logic signed [P_W-1:0]   prod_q,    prod_d;

    // done_o is high during the cycle whose edge performs the last partial-product add.
    assign done_o    = running_q && (cnt_q == CNT_W'(W - 1));
    assign product_o = prod_q;

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        running_d = running_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        if (abort_i) begin
            running_d = 1'b0;
            cnt_d     = '0;
            prod_d    = '0;
        end else if (start_i) begin
            running_d = 1'b1;
            cnt_d     = '0;
            mcand_d   = mcand_i;
            mplier_d  = mplier_i;
            prod_d    = '0;
        end else if (running_q) begin
            if (mplier_q[cnt_q]) begin
                prod_d = prod_q + (P_W'(mcand_q) <<< cnt_q);
            end
            if (done_o) begin
                running_d = 1'b0;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: reset is synchronous, sampled only on the clock edge like any other input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
        end else begin
            running_q <= running_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
        end
    end

endmodule

// File: rtl/pid_integrator.sv
// PID integral path: saturating accumulation of error samples, sequential
// multiply by K_i, then arithmetic shift and clamp into i_contrib.
module pid_integrator
    import pid_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                clr,
    input  logic signed [W-1:0] e,
    input  logic        [W-1:0] K_i,
    output logic signed [W-1:0] i_contrib,
    output logic                valid,
    output logic                busy
);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [W-1:0]     i_contrib_q, i_contrib_d;
    logic                    valid_q, valid_d;
    logic signed [ACC_W:0]   acc_sum;
    logic                    mul_start, mul_abort, mul_done;
    logic signed [P_W-1:0]   product;

    // One guard bit keeps the raw sum exact so the clamp can detect overflow.
    assign acc_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-W){e[W-1]}}, e};

    seq_shift_add_mul u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .abort_i   (mul_abort),
        .mcand_i   (acc_d),
        .mplier_i  (K_i),
        .product_o (product),
        .done_o    (mul_done)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        i_contrib_d = i_contrib_q;
        valid_d     = 1'b0;
        mul_start   = 1'b0;
        mul_abort   = 1'b0;
        if (clr) begin
            state_d     = IDLE;
            acc_d       = '0;
            i_contrib_d = '0;
            mul_abort   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: if (ena) begin
                    acc_d     = sat_acc(acc_sum);
                    mul_start = 1'b1;
                    state_d   = MUL;
                end
                MUL: if (mul_done) state_d = OUT;
                OUT: begin
                    i_contrib_d = sat_out(product[P_W-1:FRAC]);
                    valid_d     = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            i_contrib_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            i_contrib_q <= i_contrib_d;
            valid_q     <= valid_d;
        end
    end

    assign i_contrib = i_contrib_q;
    assign valid     = valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/pid_integrator.md
Name: pid_integrator

Overview:
Integral path of the PID controller, the counterpart of the differentiator: the differentiator differences successive error samples; this block accumulates them. Each accepted error sample is added into a saturating signed accumulator. The accumulator is then multiplied by K_i with a sequential shift-add multiplier, since a combinational multiplier is too large. The scaled, saturated result is presented as i_contrib with a one-cycle valid strobe, for summing with the P and D contributions.

Parameters:
W, 6, data width of e, K_i, i_contrib
ACC_W, 10, accumulator width (signed)
FRAC, 4, arithmetic right shift applied to the product before output saturation

Ports:
clk  in  1  clock
rst_n  in  1  reset
ena  in  1  sample strobe; accepted only when state is IDLE
clr  in  1  synchronous integrator clear and abort
e  in  W  error sample, two's-complement signed
K_i  in  W  integral gain, unsigned (0..63)
i_contrib  out  W  integral contribution, signed, registered
valid  out  1  one-cycle pulse when i_contrib updates
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset and clock: rst_n is synchronous, active-low; clock clk. Reset has top priority. It forces state=IDLE, acc=0, product=0, count=0, i_contrib=0, valid=0, busy=0.
- State machine:
  - States: IDLE, MUL, OUT. busy is decoded combinationally from state.
  - IDLE, ena=1 at edge T:
    - acc <= sat_ACC(acc + sext(e)), clamped to [-512, 511], never wraps.
    - mcand <= the new acc value.
    - mplier <= K_i (latched; later K_i changes are ignored).
    - P <= 0, cnt <= 0, state <= MUL.
  - MUL, edges T+1..T+W: if mplier[cnt]==1 then P <= P + (sext(mcand) << cnt). cnt increments each edge. The edge where cnt==W-1 moves state to OUT.
  - OUT, edge T+W+1 (T+7):
    - i_contrib <= sat_W(P >>> FRAC), clamped to [-32, 31]; the shift is arithmetic (floor).
    - valid <= 1 for exactly one cycle; state <= IDLE.
- Latency: ena sampled at edge T gives valid high in the cycle after edge T+7. The next ena is accepted at edge T+8 at the earliest.
- ena while busy: dropped, with no effect on acc, P or outputs.
- Product width: P is ACC_W+W = 16 bits signed. The extremes 511*63=32193 and -512*63=-32256 fit, so there is no internal overflow.
- clr (priority below rst_n, above ena):
  - Effect in any state: acc <= 0, i_contrib <= 0, P <= 0, state <= IDLE, valid <= 0.
  - An in-flight multiply is aborted and produces no valid.
  - An ena in the same cycle as clr is ignored.
- K_i=0: the full 7-cycle sequence still runs, and the output is 0.
- i_contrib holds its value between valid pulses.

Decomposition:
- Package pid_pkg:
  - W, ACC_W, FRAC constants.
  - State enum {IDLE, MUL, OUT}.
  - Saturating-clamp functions sat_acc and sat_out, shared with the P/D paths.
- Sub-module seq_shift_add_mul: start/done handshake, signed ACC_W multiplicand by unsigned W multiplier, W cycles. The integrator FSM wraps it.

Test Plan:
- Reset: rst_n=0 for 2 cycles with ena=1, e=31 -> i_contrib=0, valid=0, busy=0. After release, the first ena is accepted normally.
- Single sample: e=+3, K_i=16, ena at T -> busy high for cycles after edges T..T+6, valid pulses once after T+7, i_contrib=3 (48>>>4).
- Accumulation and negative floor:
  - Three samples e=+3, K_i=16, spaced 8 cycles -> outputs 3, 6, 9.
  - After clr, e=-5, K_i=63 -> P=-315, i_contrib=-20 (6'b101100).
- Saturation:
  - 20 samples e=+31, K_i=1 -> acc clamps at 511, i_contrib=31.
  - Then e=-32 -> acc=479, i_contrib=29; a wrap or missing clamp gives a different value.
  - Output clamp: after clr, e=-20, K_i=63 -> P=-1260, i_contrib=-32.
- Handshake, abort and K_i latching:
  - ena at T and again at T+3 -> second ena ignored, a single valid.
  - clr at T+3 -> no valid, i_contrib=0, busy low after T+3.
  - K_i changed mid-MUL -> result uses the latched K_i.
